morse_decoder: RTL and testbench

MORSE_DECODER -- requirements
Module: morse_decoder

---
 rtl/morse_decoder.sv | 192 +++++++++++++++++++
 tb/tb_morse_decoder.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/morse_decoder.sv
// Single-key Morse receiver: times marks and spaces on a filtered key and emits ASCII characters.
// Optional key debounce filter is enabled by defining MORSE_DEBOUNCE_EN.
module morse_decoder #(
  parameter int unsigned UNIT_TICKS     = 4800000,
  parameter int unsigned DEBOUNCE_TICKS = 48000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_n,
  output logic [7:0] char,
  output logic       char_valid,
  output logic       busy,
  output logic       led_r
);

  localparam int unsigned CntW = 26;
  localparam int unsigned DurW = CntW + 1;
  localparam logic [DurW-1:0] TwoUnit  = DurW'(2 * UNIT_TICKS);
  localparam logic [DurW-1:0] FiveUnit = DurW'(5 * UNIT_TICKS);

  typedef enum logic [1:0] {StIdle, StMark, StSpace, StWord} state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic            key_prev_q, key_prev_d;
  logic [1:0]      fill_q, fill_d;
  logic            arm_q, arm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [4:0]      pat_q, pat_d;
  logic [2:0]      len_q, len_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      char_q, char_d;
  logic            valid_q, valid_d;

  logic            filt;
  logic            key_edge, press, rel;
  logic [DurW-1:0] dur;
  logic [7:0]      letter;

`ifdef MORSE_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_TICKS + 1);
  logic [DbW-1:0] db_cnt_q, db_cnt_d;
  logic           filt_q, filt_d;

  always_comb begin
    db_cnt_d = '0;
    filt_d   = filt_q;
    if (sync_q[1] != filt_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_TICKS - 1)) filt_d = sync_q[1];
      else db_cnt_d = db_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      filt_q   <= 1'b1;
    end else begin
      db_cnt_q <= db_cnt_d;
      filt_q   <= filt_d;
    end
  end

  assign filt = filt_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_TICKS;
  assign filt = sync_q[1];
`endif

  function automatic logic [7:0] decode(input logic [2:0] len, input logic [4:0] pat);
    logic [7:0] c;
    case ({len, pat})
      {3'd1, 5'b00000}: c = 8'h45;  {3'd1, 5'b00001}: c = 8'h54;
      {3'd2, 5'b00000}: c = 8'h49;  {3'd2, 5'b00001}: c = 8'h41;
      {3'd2, 5'b00010}: c = 8'h4E;  {3'd2, 5'b00011}: c = 8'h4D;
      {3'd3, 5'b00000}: c = 8'h53;  {3'd3, 5'b00001}: c = 8'h55;
      {3'd3, 5'b00010}: c = 8'h52;  {3'd3, 5'b00011}: c = 8'h57;
      {3'd3, 5'b00100}: c = 8'h44;  {3'd3, 5'b00101}: c = 8'h4B;
      {3'd3, 5'b00110}: c = 8'h47;  {3'd3, 5'b00111}: c = 8'h4F;
      {3'd4, 5'b00000}: c = 8'h48;  {3'd4, 5'b00001}: c = 8'h56;
      {3'd4, 5'b00010}: c = 8'h46;  {3'd4, 5'b00100}: c = 8'h4C;
      {3'd4, 5'b00110}: c = 8'h50;  {3'd4, 5'b00111}: c = 8'h4A;
      {3'd4, 5'b01000}: c = 8'h42;  {3'd4, 5'b01001}: c = 8'h58;
      {3'd4, 5'b01010}: c = 8'h43;  {3'd4, 5'b01011}: c = 8'h59;
      {3'd4, 5'b01100}: c = 8'h5A;  {3'd4, 5'b01101}: c = 8'h51;
      {3'd5, 5'b00000}: c = 8'h35;  {3'd5, 5'b00001}: c = 8'h34;
      {3'd5, 5'b00011}: c = 8'h33;  {3'd5, 5'b00111}: c = 8'h32;
      {3'd5, 5'b01111}: c = 8'h31;  {3'd5, 5'b11111}: c = 8'h30;
      {3'd5, 5'b10000}: c = 8'h36;  {3'd5, 5'b11000}: c = 8'h37;
      {3'd5, 5'b11100}: c = 8'h38;  {3'd5, 5'b11110}: c = 8'h39;
      default:          c = 8'h3F;
    endcase
    return c;
  endfunction

  // Key timing: one counter measures both marks and spaces, restarted on every filtered edge.
  always_comb begin
    sync_d     = {sync_q[0], key_n};
    key_prev_d = filt;
    fill_d     = {fill_q[0], 1'b1};
    // Arm only once a genuine release has been seen after reset.
    arm_d      = arm_q | (fill_q[1] & sync_q[1] & filt);
    key_edge   = (filt != key_prev_q);
    cnt_d      = key_edge ? '0 : ((&cnt_q) ? cnt_q : cnt_q + 1'b1);
    dur        = {1'b0, cnt_q} + 1'b1;
    press      = key_edge & ~filt & arm_q;
    rel        = key_edge & filt;
  end

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    len_d   = len_q;
    ovf_d   = ovf_q;
    char_d  = char_q;
    valid_d = 1'b0;
    letter  = ovf_q ? 8'h3F : decode(len_q, pat_q);
    unique case (state_q)
      StIdle: begin
        if (press) state_d = StMark;
      end
      StMark: begin
        if (rel) begin
          state_d = StSpace;
          if (len_q == 3'd5) begin
            ovf_d = 1'b1;
          end else begin
            pat_d = {pat_q[3:0], dur >= TwoUnit};
            len_d = len_q + 3'd1;
          end
        end
      end
      StSpace: begin
        if (dur >= TwoUnit) begin
          char_d  = letter;
          valid_d = 1'b1;
          pat_d   = '0;
          len_d   = '0;
          ovf_d   = 1'b0;
          state_d = press ? StMark : StWord;
        end else if (press) begin
          state_d = StMark;
        end
      end
      StWord: begin
        if (dur >= FiveUnit) begin
          char_d  = 8'h20;
          valid_d = 1'b1;
          state_d = press ? StMark : StIdle;
        end else if (press) begin
          state_d = StMark;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      sync_q     <= 2'b11;
      key_prev_q <= 1'b1;
      fill_q     <= 2'b00;
      arm_q      <= 1'b0;
      cnt_q      <= '0;
      pat_q      <= '0;
      len_q      <= '0;
      ovf_q      <= 1'b0;
      char_q     <= 8'h00;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      key_prev_q <= key_prev_d;
      fill_q     <= fill_d;
      arm_q      <= arm_d;
      cnt_q      <= cnt_d;
      pat_q      <= pat_d;
      len_q      <= len_d;
      ovf_q      <= ovf_d;
      char_q     <= char_d;
      valid_q    <= valid_d;
    end
  end

  assign char       = char_q;
  assign char_valid = valid_q;
  assign busy       = (state_q != StIdle);
  assign led_r      = key_prev_q;

endmodule

// File: tb/tb_morse_decoder.sv
// Scoreboard bench for morse_decoder: a Morse-table model predicts characters from keyed symbols.
module tb_morse_decoder;

  localparam int U = 10;

  logic       clk;
  logic       rst;
  logic       key_n;
  logic [7:0] char;
  logic       char_valid;
  logic       busy;
  logic       led_r;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  string morse_tab [36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                            "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                            "..-", "...-", ".--", "-..-", "-.--", "--..", "-----", ".----",
                            "..---", "...--", "....-", ".....", "-....", "--...", "---..",
                            "----."};
  string alpha = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

  morse_decoder #(
    .UNIT_TICKS     (U),
    .DEBOUNCE_TICKS (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .char       (char),
    .char_valid (char_valid),
    .busy       (busy),
    .led_r      (led_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lookup(input string s);
    logic [7:0] c;
    c = 8'h3F;
    for (int i = 0; i < 36; i++) begin
      if (s == morse_tab[i]) c = alpha[i];
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    key_n = lvl;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Durations of 0 mean "pick a random legal duration for that symbol kind".
  task automatic send(input string syms, input int dot_len, input int dash_len,
                      input int intra, input int gap);
    int d;
    exp_q.push_back(lookup(syms));
    if (gap >= 5 * U) exp_q.push_back(8'h20);
    for (int i = 0; i < syms.len(); i++) begin
      if (syms[i] == "-") d = (dash_len != 0) ? dash_len : int'($urandom_range(2 * U, 4 * U));
      else d = (dot_len != 0) ? dot_len : int'($urandom_range(1, 2 * U - 1));
      drive(1'b0, d);
      if (i == 0 && d >= 4) chk("busy_in_mark", {7'd0, busy}, 8'd1);
      if (i != syms.len() - 1) begin
        drive(1'b1, (intra != 0) ? intra : int'($urandom_range(1, 2 * U - 1)));
      end
    end
    drive(1'b1, gap);
    if (gap >= 5 * U + 5) chk("busy_after_word", {7'd0, busy}, 8'd0);
  endtask

  initial begin : monitor
    logic [7:0] e;
    logic prev_valid;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && char_valid) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_char: got %h expected none", char);
        end else begin
          e = exp_q.pop_front();
          if (char !== e) begin
            n_err++;
            $display("FAIL char: got %h expected %h", char, e);
          end
        end
        if (prev_valid) begin
          n_err++;
          $display("FAIL back_to_back_strobe: got 2 consecutive expected 1");
        end
      end
      prev_valid = char_valid;
    end
  end

  initial begin : stim
    string s;
    int n;
    rst   = 1'b1;
    key_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_char", char, 8'h00);
    chk("reset_valid", {7'd0, char_valid}, 8'd0);
    chk("reset_busy", {7'd0, busy}, 8'd0);
    chk("reset_led", {7'd0, led_r}, 8'd1);
    rst = 1'b0;
    drive(1'b1, 5);

    // Directed: E with gap expiring on the next press, dot/dash boundary, SOS, overflow, word.
    send(".", 10, 0, 10, 2 * U);
    send(".", 19, 0, 10, 30);
    send("-", 0, 20, 10, 30);
    send("...", 10, 30, 10, 30);
    send("---", 10, 30, 10, 30);
    send("...", 10, 30, 10, 200);
    send("......", 10, 30, 10, 30);
    send(".", 10, 30, 10, 200);

    // Reset in the middle of a dash with the key still held afterwards.
    drive(1'b0, 15);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_char", char, 8'h00);
    chk("midreset_valid", {7'd0, char_valid}, 8'd0);
    chk("midreset_busy", {7'd0, busy}, 8'd0);
    chk("midreset_led", {7'd0, led_r}, 8'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b0, 30);
    chk("held_key_ignored", {7'd0, busy}, 8'd0);
    drive(1'b1, 100);
    chk("idle_after_release", {7'd0, busy}, 8'd0);

    for (int k = 0; k < 40; k++) begin
      s = "";
      n = int'($urandom_range(1, 6));
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 1) == 1) s = {s, "-"};
        else s = {s, "."};
      end
      if ($urandom_range(0, 2) == 0) send(s, 0, 0, 0, int'($urandom_range(5 * U, 8 * U)));
      else send(s, 0, 0, 0, int'($urandom_range(2 * U, 5 * U - 1)));
    end
    drive(1'b1, 100);

    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL missing_chars: got %0d outstanding expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
